alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 Parameter CNT_BITS, default $clog2(XLEN)+1, iteration counter width.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  abort any in-flight operation.
REQ-006 in_valid  input  1  operands/op presented.
REQ-007 in_ready  output  1  block accepts a new operation.
REQ-008 op  input  3  RISC-V M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 rdata1  input  XLEN  first operand, rs1, dividend or multiplicand.
REQ-010 rdata2  input  XLEN  second operand, rs2, divisor or multiplier.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 result  output  XLEN  operation result.
REQ-014 is_zero  output  1  result == 0, qualified by out_valid.
REQ-015 busy  output  1  high in CALC or DONE.

Function
REQ-016 FSM states: IDLE, CALC, DONE.
REQ-017 in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 Accept = in_valid & in_ready at an edge; op, operand signs and operand magnitudes latch at that edge.
REQ-019 Signedness: MUL/MULH/DIV/REM both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned.
REQ-020 IDLE -> CALC on normal accept; counter cleared to 0.
REQ-021 CALC: one shift-add (mul) or restoring shift-subtract (div) iteration per cycle on magnitudes; counter +1 per cycle.
REQ-022 CALC -> DONE when counter == XLEN-1; the sign correction is applied on that same edge, so out_valid rises exactly XLEN+1 edges after the accept edge.
REQ-023 MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN] of the full 2*XLEN-bit product.
REQ-024 DIV quotient is negated when the operand signs differ; REM remainder takes the dividend's sign.
REQ-025 Divide by zero (rdata2 == 0, op 4..7) -> IDLE to DONE directly, out_valid 1 edge after accept; DIV/DIVU return all-ones, REM/REMU return rdata1.
REQ-026 Signed overflow (DIV/REM, rdata1 = 1 followed by zeros, rdata2 = all-ones) -> DONE directly in 1 edge; DIV returns rdata1, REM returns 0.
REQ-027 DONE holds result and is_zero stable while out_ready = 0; DONE -> IDLE on out_valid & out_ready; no accept occurs in that same cycle.
REQ-028 flush forces IDLE on the next edge from any state, discards the operation, and suppresses out_valid; flush has priority over accept and over out_ready.
REQ-029 Operand inputs are ignored outside an accept edge.

Reset
REQ-030 rst = 1 at an edge -> state IDLE, counter 0, result 0, out_valid 0, busy 0, is_zero 0, in_ready 1 after the edge; rst has priority over flush and over every handshake.
REQ-031 rst asserted mid-CALC or in DONE abandons the operation with no out_valid.

Structure
REQ-032 Package alu_pkg holds the op encoding localparams, the FSM state enum and the ALU_BITS default.
REQ-033 One sub-module, muldiv_step: combinational single iteration taking partial value, operand and mode, returning the next partial value and quotient bit.
REQ-034 Target size 120-400 lines of RTL; no multiplier or divider operators (* / %) are inferred.

Verification
REQ-035 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid on edge 33 after accept.
REQ-036 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000, is_zero 1.
REQ-037 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-038 DIVU 5 / 0 -> 0xFFFFFFFF on edge 1; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, both on edge 1.
REQ-039 out_ready held low 5 cycles in DONE -> result stable, in_ready 0; then out_ready 1 -> IDLE next edge.
REQ-040 flush at counter 10 of a DIV -> IDLE next edge, out_valid never rises; rst during DONE -> all outputs equal their reset values.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative RISC-V M-extension multiply/divide unit.
package alu_pkg;

    // Default operand/result width.
    localparam int ALU_BITS = 32;

    // RISC-V M funct3 encodings.
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic rs1_is_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM.
    function automatic logic rs2_is_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Upper half of the funct3 space is the divide family.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One combinational iteration shared by the shift-add multiplier and the
// restoring divider. Operates purely on unsigned magnitudes.
module muldiv_step
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_BITS
) (
    input  logic [XLEN-1:0] i_part,     // mul: upper product half; div: partial remainder
    input  logic            i_lo_bit,   // mul: current multiplier bit; div: next dividend bit
    input  logic [XLEN-1:0] i_operand,  // multiplicand or divisor magnitude
    input  logic            i_is_div,   // 1 selects the divide iteration
    output logic [XLEN-1:0] o_part,     // next upper half / partial remainder
    output logic            o_bit       // mul: product bit shifted out; div: quotient bit
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    // Evaluate both iteration kinds and select by mode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        o_part  = '0;
        o_bit   = 1'b0;
        // Shift-add: add the multiplicand when the multiplier bit is set, then shift right.
        w_sum   = {1'b0, i_part} + (i_lo_bit ? {1'b0, i_operand} : '0);
        // Restoring divide: shift the next dividend bit in and try a subtract.
        w_shift = {i_part, i_lo_bit};
        w_ge    = (w_shift >= {1'b0, i_operand});
        // When w_ge holds the difference is below the divisor, so XLEN bits suffice.
        w_diff  = w_shift[XLEN-1:0] - i_operand;
        if (i_is_div) begin
            o_part = w_ge ? w_diff : w_shift[XLEN-1:0];
            o_bit  = w_ge;
        end else begin
            o_part = w_sum[XLEN:1];
            o_bit  = w_sum[0];
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit. One shift-add or
// restoring shift-subtract step per cycle on operand magnitudes, with the
// sign fix-up applied on the final step. Divide-by-zero and signed overflow
// complete without iterating.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN     = ALU_BITS,
    parameter int CNT_BITS = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            is_zero,
    output logic            busy
);

    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(XLEN - 1);
    localparam logic [XLEN-1:0]     MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Control state
    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_BITS-1:0] r_cnt;

    // Operation context captured at accept
    logic [2:0]          r_op;
    logic                r_neg;       // final result must be negated
    logic [XLEN-1:0]     r_operand;   // multiplicand or divisor magnitude
    logic [XLEN-1:0]     r_hi;        // upper product half / partial remainder
    logic [XLEN-1:0]     r_lo;        // multiplier / dividend, becomes product low / quotient
    logic [XLEN-1:0]     r_result;

    // Accept-time decode
    logic                w_accept;
    logic                w_rs1_neg;
    logic                w_rs2_neg;
    logic                w_neg;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic                w_div_zero;
    logic                w_overflow;
    logic                w_special;

    // Iteration datapath
    logic                w_is_div;
    logic                w_last;
    logic                w_calc_step;
    logic                w_step_in_bit;
    logic [XLEN-1:0]     w_step_part;
    logic                w_step_bit;
    logic [XLEN-1:0]     w_next_hi;
    logic [XLEN-1:0]     w_next_lo;

    // Sign fix-up
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quot_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_final;

    // Decode operand signs, magnitudes and early-completion cases at the input.
    always_comb begin
        w_accept   = in_valid && in_ready && !flush;
        w_rs1_neg  = rs1_is_signed(op) && rdata1[XLEN-1];
        w_rs2_neg  = rs2_is_signed(op) && rdata2[XLEN-1];
        w_mag1     = w_rs1_neg ? (~rdata1 + 1'b1) : rdata1;
        w_mag2     = w_rs2_neg ? (~rdata2 + 1'b1) : rdata2;
        // Remainder follows the dividend; everything else follows the sign product.
        w_neg      = (op == OP_REM) ? w_rs1_neg : (w_rs1_neg ^ w_rs2_neg);
        w_div_zero = op_is_div(op) && (rdata2 == '0);
        w_overflow = ((op == OP_DIV) || (op == OP_REM)) &&
                     (rdata1 == MOST_NEG) && (rdata2 == '1);
        w_special  = w_div_zero || w_overflow;
    end

    // Route the low register bit the step needs and rebuild the low register.
    always_comb begin
        w_is_div      = op_is_div(r_op);
        w_last        = (r_cnt == LAST_CNT);
        w_calc_step   = (r_state == ST_CALC) && !flush;
        w_step_in_bit = w_is_div ? r_lo[XLEN-1] : r_lo[0];
        w_next_hi     = w_step_part;
        w_next_lo     = w_is_div ? {r_lo[XLEN-2:0], w_step_bit}
                                 : {w_step_bit, r_lo[XLEN-1:1]};
    end

    muldiv_step #(
        .XLEN      (XLEN)
    ) u_step (
        .i_part    (r_hi),
        .i_lo_bit  (w_step_in_bit),
        .i_operand (r_operand),
        .i_is_div  (w_is_div),
        .o_part    (w_step_part),
        .o_bit     (w_step_bit)
    );

    // Apply the sign correction to the values produced by the last iteration.
    always_comb begin
        w_prod     = {w_next_hi, w_next_lo};
        w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;
        w_quot_fix = r_neg ? (~w_next_lo + 1'b1) : w_next_lo;
        w_rem_fix  = r_neg ? (~w_next_hi + 1'b1) : w_next_hi;
        case (r_op)
            OP_MUL:                        w_final = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_final = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_final = w_quot_fix;
            default:                       w_final = w_rem_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next_state = w_special ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last)   w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default:               w_next_state = ST_IDLE;
        endcase
        if (flush) begin
            w_next_state = ST_IDLE;
        end
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        busy      = (r_state == ST_CALC) || (r_state == ST_DONE);
        is_zero   = (r_state == ST_DONE) && (r_result == '0);
        result    = r_result;
    end

    // Counter and result, the only datapath registers with visible reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            if (w_div_zero) begin
                // op[1] separates REM/REMU from DIV/DIVU.
                r_result <= op[1] ? rdata1 : '1;
            end else if (w_overflow) begin
                r_result <= op[1] ? '0 : rdata1;
            end
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_calc_step) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end

    // Operation context and iteration registers.
    always_ff @(posedge clk) begin
        // NOTE: these are always loaded on accept before use, so they carry no reset.
        if (w_accept) begin
            r_op <= op;
            r_neg <= w_neg;
            r_hi <= '0;
            if (op_is_div(op)) begin
                r_operand <= w_mag2;
                r_lo      <= w_mag1;
            end else begin
                r_operand <= w_mag1;
                r_lo      <= w_mag2;
            end
        end else if (w_calc_step) begin
            r_hi <= w_next_hi;
            r_lo <= w_next_lo;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv with a result scoreboard.
module tb_alu_muldiv;
    import alu_pkg::*;

    localparam int XLEN = 32;
    localparam int MAX_WAIT = 100;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            is_zero;
    logic            busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard entries: {expected is_zero, expected result}
    logic [XLEN:0] sb_q[$];

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .is_zero   (is_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference results from wide native arithmetic.
    function automatic logic [XLEN-1:0] ref_model(input logic [2:0] o,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic signed [63:0] sa, sb, sq;
        logic [63:0]        ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (o)
            OP_MUL:    begin p = ua * ub;           return p[31:0];  end
            OP_MULH:   begin p = sa * sb;           return p[63:32]; end
            OP_MULHSU: begin p = sa * $signed(ub);  return p[63:32]; end
            OP_MULHU:  begin p = ua * ub;           return p[63:32]; end
            OP_DIV:    begin if (b == 0) return '1; sq = sa / sb; return sq[31:0]; end
            OP_DIVU:   begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
            OP_REM:    begin if (b == 0) return a;  sq = sa % sb; return sq[31:0]; end
            default:   begin if (b == 0) return a;  p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Edge (accept edge = 1) after which out_valid must be high.
    function automatic int exp_latency(input logic [2:0] o, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Issue one operation and wait until out_valid; leaves the DUT in DONE.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] e;
        logic [XLEN:0]   exp_entry;
        int              lat;
        e = ref_model(o, a, b);
        sb_q.push_back({(e == '0), e});
        check({tag, " in_ready"}, 64'(in_ready), 64'(1));
        op = o; rdata1 = a; rdata2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); rdata1 = $urandom; rdata2 = $urandom;
        lat = 1;
        while (!out_valid && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_latency(o, a, b)));
        exp_entry = sb_q.pop_front();
        if (out_valid) begin
            check({tag, " result"}, 64'(result), 64'(exp_entry[XLEN-1:0]));
            check({tag, " is_zero"}, 64'(is_zero), 64'(exp_entry[XLEN]));
        end
    endtask

    // Take the result with an attempted accept in the same cycle.
    task automatic consume(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " idle after take"}, 64'({in_ready, out_valid, busy}), 64'(3'b100));
    endtask

    initial begin
        int n_ov;
        logic [XLEN-1:0] hold_exp;
        logic [2:0]      r_o;
        logic [XLEN-1:0] r_a, r_b;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; rdata1 = '0; rdata2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready",  64'(in_ready),  64'(1));
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset busy",      64'(busy),      64'(0));
        check("reset is_zero",   64'(is_zero),   64'(0));
        check("reset result",    64'(result),    64'(0));
        rst = 1'b0;

        // Core arithmetic
        run_op("mul_7xm3", OP_MUL, 32'd7, 32'hFFFF_FFFD);
        check("mul_7xm3 literal", 64'(result), 64'(32'hFFFF_FFEB));
        consume("mul_7xm3");
        run_op("mulhu_ones", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        consume("mulhu_ones");
        run_op("mulh_ones", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulh_ones zero flag", 64'(is_zero), 64'(1));
        consume("mulh_ones");
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        consume("div_m7_2");
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
        consume("rem_m7_2");
        run_op("mulhsu_neg", OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF);
        consume("mulhsu_neg");
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFF0, 32'd7);
        consume("divu_big");
        run_op("remu_big", OP_REMU, 32'hFFFF_FFF0, 32'd7);
        consume("remu_big");
        run_op("rem_negdiv", OP_REM, 32'd100, 32'hFFFF_FFF9);
        consume("rem_negdiv");

        // Early-completion cases
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0);
        consume("divu_by0");
        run_op("remu_by0", OP_REMU, 32'd5, 32'd0);
        consume("remu_by0");
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        consume("div_ovf");
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        consume("rem_ovf");

        // Back-pressure: result held while out_ready is low
        out_ready = 1'b0;
        hold_exp  = ref_model(OP_MUL, 32'h0000_1234, 32'h0000_0010);
        run_op("hold", OP_MUL, 32'h0000_1234, 32'h0000_0010);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold result",   64'(result), 64'(hold_exp));
            check("hold handshake", 64'({out_valid, in_ready}), 64'(2'b10));
        end
        consume("hold");

        // Flush part-way through a divide
        op = OP_DIV; rdata1 = 32'd1000; rdata2 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("flush pre busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush idle", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        n_ov = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) n_ov++;
        end
        check("flush no out_valid", 64'(n_ov), 64'(0));

        // Flush wins over a simultaneous accept
        op = OP_MUL; rdata1 = 32'd3; rdata2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush beats accept", 64'(busy), 64'(0));

        // Flush in DONE with out_ready low
        out_ready = 1'b0;
        run_op("flush_done", OP_DIVU, 32'd9, 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_done idle", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        out_ready = 1'b1;

        // Mixed operations
        for (int i = 0; i < 8; i++) begin
            r_o = 3'(i);
            r_a = $urandom;
            r_b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_op($sformatf("mix%0d", i), r_o, r_a, r_b);
            consume($sformatf("mix%0d", i));
        end

        // Reset while in DONE
        out_ready = 1'b0;
        run_op("rst_done", OP_MUL, 32'd6, 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_done flags", 64'({in_ready, out_valid, busy, is_zero}), 64'(4'b1000));
        check("rst_done result", 64'(result), 64'(0));
        out_ready = 1'b1;

        // Reset mid-calculation abandons the operation
        op = OP_MULHU; rdata1 = 32'hDEAD_BEEF; rdata2 = 32'h1234_5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_ov = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || busy) n_ov++;
        end
        check("rst_calc abandoned", 64'(n_ov), 64'(0));

        check("scoreboard drained", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
